// File: rtl/dual_port_mem_arbiter_if.sv
// Requester-side bus of the shared two-port RAM arbiter: per-requester request,
// write enable, address and write data, plus grant and read-return lanes.
interface dual_port_mem_arbiter_if #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned address_length = 10,
  parameter int unsigned word_length    = 64
);
  logic [NUM_REQ-1:0]                req;
  logic [NUM_REQ-1:0]                we;
  logic [NUM_REQ*address_length-1:0] addr;
  logic [NUM_REQ*word_length-1:0]    wdata;
  logic [NUM_REQ-1:0]                gnt;
  logic [NUM_REQ-1:0]                rvalid;
  logic [NUM_REQ*word_length-1:0]    rdata;

  // Requesters (core memory stages) drive the access; they observe grant and read return.
  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  // The arbiter samples the accesses and answers with grant and read return.
  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dual_port_mem_arbiter.sv
// Round-robin arbiter granting up to two requesters per cycle onto the two ports of a
// shared RAM, and steering each port's registered read data back to its owner.
module dual_port_mem_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned address_length = 10,
  parameter int unsigned word_length    = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  dual_port_mem_arbiter_if.slave    bus,
  output logic [address_length-1:0] address_a,
  output logic [address_length-1:0] address_b,
  output logic [word_length-1:0]    data_a,
  output logic [word_length-1:0]    data_b,
  output logic                      wren_a,
  output logic                      wren_b,
  input  logic [word_length-1:0]    q_a,
  input  logic [word_length-1:0]    q_b
);

  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [IdW-1:0] id_t;

  typedef struct packed {
    logic valid;
    logic is_read;
    id_t  id;
  } owner_t;

  id_t    ptr_q, ptr_d;
  owner_t own_a_q, own_a_d;
  owner_t own_b_q, own_b_d;
  logic   a_hit, b_hit, conflict;
  logic   a_gnt, b_gnt;
  id_t    a_id, b_id;

  logic [address_length-1:0] addr_arr  [NUM_REQ];
  logic [word_length-1:0]    wdata_arr [NUM_REQ];

  function automatic id_t wrap_inc(input id_t i);
    if (i == id_t'(NUM_REQ - 1)) return '0;
    return i + 1'b1;
  endfunction

  // Unpack the flat requester buses into per-requester lanes.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = bus.addr[i*address_length +: address_length];
      wdata_arr[i] = bus.wdata[i*word_length +: word_length];
    end
  end

  // Port A: first requester from ptr; port B: next requester after A's winner.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    a_hit = 1'b0;
    a_id  = '0;
    b_hit = 1'b0;
    b_id  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr_q) + k) % NUM_REQ;
      if (!a_hit && bus.req[id_t'(idx)]) begin
        a_hit = 1'b1;
        a_id  = id_t'(idx);
      end
    end
    for (int unsigned k = 1; k < NUM_REQ; k++) begin
      idx = (32'(a_id) + k) % NUM_REQ;
      if (a_hit && !b_hit && bus.req[id_t'(idx)]) begin
        b_hit = 1'b1;
        b_id  = id_t'(idx);
      end
    end
    // Same address with any write on either side: B backs off so ordering stays defined.
    conflict = b_hit && (addr_arr[a_id] == addr_arr[b_id]) && (bus.we[a_id] || bus.we[b_id]);
    a_gnt    = a_hit && !reset;
    b_gnt    = b_hit && !conflict && !reset;
  end

  // Drive grants and RAM ports; idle ports are held at zero.
  always_comb begin
    bus.gnt   = '0;
    address_a = '0;
    data_a    = '0;
    wren_a    = 1'b0;
    address_b = '0;
    data_b    = '0;
    wren_b    = 1'b0;
    if (a_gnt) begin
      bus.gnt[a_id] = 1'b1;
      address_a     = addr_arr[a_id];
      data_a        = wdata_arr[a_id];
      wren_a        = bus.we[a_id];
    end
    if (b_gnt) begin
      bus.gnt[b_id] = 1'b1;
      address_b     = addr_arr[b_id];
      data_b        = wdata_arr[b_id];
      wren_b        = bus.we[b_id];
    end
  end

  // Next pointer follows the last granted requester; owners record who gets q next cycle.
  always_comb begin
    ptr_d   = ptr_q;
    own_a_d = '0;
    own_b_d = '0;
    if (b_gnt) begin
      ptr_d = wrap_inc(b_id);
    end else if (a_gnt) begin
      ptr_d = wrap_inc(a_id);
    end
    if (a_gnt) own_a_d = '{valid: 1'b1, is_read: !bus.we[a_id], id: a_id};
    if (b_gnt) own_b_d = '{valid: 1'b1, is_read: !bus.we[b_id], id: b_id};
  end

  // Arbitration state; async reset also drops any read granted in the reset cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q   <= '0;
      own_a_q <= '0;
      own_b_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      own_a_q <= own_a_d;
      own_b_q <= own_b_d;
    end
  end

  // Route registered RAM read data to the requester that owned each port last cycle.
  always_comb begin
    bus.rvalid = '0;
    bus.rdata  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (own_a_q.valid && own_a_q.is_read && (own_a_q.id == id_t'(i))) begin
        bus.rvalid[i]                          = 1'b1;
        bus.rdata[i*word_length +: word_length] = q_a;
      end
      if (own_b_q.valid && own_b_q.is_read && (own_b_q.id == id_t'(i))) begin
        bus.rvalid[i]                          = 1'b1;
        bus.rdata[i*word_length +: word_length] = q_b;
      end
    end
  end

endmodule

// File: tb/tb_dual_port_mem_arbiter.sv
// Bench for dual_port_mem_arbiter: directed scenarios followed by random traffic, with a
// behavioural RAM and a round-robin reference model that predicts grants and read returns.
module tb_dual_port_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dual_port_mem_arbiter_if #(.NUM_REQ(N), .address_length(AW), .word_length(DW)) bus ();

  logic [AW-1:0] address_a, address_b;
  logic [DW-1:0] data_a, data_b, q_a, q_b;
  logic          wren_a, wren_b;

  dual_port_mem_arbiter #(.NUM_REQ(N), .address_length(AW), .word_length(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .address_a (address_a),
    .address_b (address_b),
    .data_a    (data_a),
    .data_b    (data_b),
    .wren_a    (wren_a),
    .wren_b    (wren_b),
    .q_a       (q_a),
    .q_b       (q_b)
  );

  function automatic logic [DW-1:0] init_word(input int unsigned a);
    return 64'(a) * 64'h9E37_79B9_7F4A_7C15 + 64'h1;
  endfunction

  // Behavioural two-port RAM with registered read (read-before-write per port).
  logic [DW-1:0] ram [1024];
  bit            ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
      ram_ready <= 1'b1;
    end else begin
      if (wren_a) ram[address_a] <= data_a;
      if (wren_b) ram[address_b] <= data_b;
      q_a <= ram[address_a];
      q_b <= ram[address_b];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Requester stimulus state.
  bit            act [N];
  bit            w   [N];
  logic [AW-1:0] ad  [N];
  logic [DW-1:0] wd  [N];

  // Reference model state.
  logic [DW-1:0]   mmem [1024];
  int              mptr;
  logic [N-1:0]    exp_rv;
  logic [N*DW-1:0] exp_rd;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic new_access(input int i);
    act[i] = ($urandom_range(0, 3) != 0);
    w[i]   = 1'($urandom_range(0, 1));
    ad[i]  = AW'($urandom_range(0, 15));
    wd[i]  = {$urandom, $urandom};
  endtask

  // One cycle: drive requests, compare against the model, then advance the model.
  task automatic step(input bit renew);
    int              order[$];
    int              ga, gb;
    logic [N-1:0]    eg;
    logic [AW-1:0]   ea_a, ea_b;
    logic [DW-1:0]   ed_a, ed_b;
    logic            ew_a, ew_b;
    logic [N-1:0]    nrv;
    logic [N*DW-1:0] nrd;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      bus.req[i]             = act[i];
      bus.we[i]              = w[i];
      bus.addr[i*AW +: AW]   = ad[i];
      bus.wdata[i*DW +: DW]  = wd[i];
    end
    #1;
    order = {};
    for (int k = 0; k < N; k++) if (act[(mptr + k) % N]) order.push_back((mptr + k) % N);
    ga = (order.size() > 0) ? order[0] : -1;
    gb = (order.size() > 1) ? order[1] : -1;
    if (gb >= 0 && ad[ga] == ad[gb] && (w[ga] || w[gb])) gb = -1;
    eg = '0; ea_a = '0; ed_a = '0; ew_a = 1'b0; ea_b = '0; ed_b = '0; ew_b = 1'b0;
    if (ga >= 0) begin eg[ga] = 1'b1; ea_a = ad[ga]; ed_a = wd[ga]; ew_a = w[ga]; end
    if (gb >= 0) begin eg[gb] = 1'b1; ea_b = ad[gb]; ed_b = wd[gb]; ew_b = w[gb]; end
    chk("gnt", bus.gnt, eg);
    chk("address_a", address_a, ea_a);
    chk("data_a", data_a, ed_a);
    chk("wren_a", wren_a, ew_a);
    chk("address_b", address_b, ea_b);
    chk("data_b", data_b, ed_b);
    chk("wren_b", wren_b, ew_b);
    chk("rvalid", bus.rvalid, exp_rv);
    chk("rdata", bus.rdata, exp_rd);
    nrv = '0;
    nrd = '0;
    if (ga >= 0 && !w[ga]) begin nrv[ga] = 1'b1; nrd[ga*DW +: DW] = mmem[ad[ga]]; end
    if (gb >= 0 && !w[gb]) begin nrv[gb] = 1'b1; nrd[gb*DW +: DW] = mmem[ad[gb]]; end
    if (ga >= 0 && w[ga]) mmem[ad[ga]] = wd[ga];
    if (gb >= 0 && w[gb]) mmem[ad[gb]] = wd[gb];
    if (gb >= 0) mptr = (gb + 1) % N;
    else if (ga >= 0) mptr = (ga + 1) % N;
    exp_rv = nrv;
    exp_rd = nrd;
    if (renew) begin
      if (ga >= 0) new_access(ga);
      if (gb >= 0) new_access(gb);
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin act[i] = 1'b0; w[i] = 1'b0; ad[i] = '0; wd[i] = '0; end
  endtask

  // Hold reset with all requests raised; everything must stay quiet, then release cleanly.
  task automatic do_reset();
    reset   = 1'b1;
    bus.req = '1;
    bus.we  = '1;
    #1;
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_wren", {wren_a, wren_b}, 0);
    chk("rst_addr", {address_a, address_b}, 0);
    chk("rst_data", {data_a, data_b}, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rdata", bus.rdata, 0);
    repeat (2) @(negedge clk);
    bus.req = '0;
    bus.we  = '0;
    clear_reqs();
    reset  = 1'b0;
    mptr   = 0;
    exp_rv = '0;
    exp_rd = '0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mmem[i] = init_word(i);
    bus.req   = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    clear_reqs();
    do_reset();

    // Single read from requester 0.
    act[0] = 1'b1; ad[0] = 10'h010;
    step(0);
    chk("single_gnt", bus.gnt, 4'b0001);
    act[0] = 1'b0;
    step(0);
    chk("single_rvalid", bus.rvalid, 4'b0001);
    chk("single_rdata", bus.rdata[0 +: DW], init_word(10'h010));

    // Write/read conflict on 0x20 with ptr at 1: write wins alone, read follows on port A.
    act[1] = 1'b1; w[1] = 1'b1; ad[1] = 10'h020; wd[1] = 64'h5;
    act[2] = 1'b1; w[2] = 1'b0; ad[2] = 10'h020;
    step(0);
    chk("conf_gnt", bus.gnt, 4'b0010);
    act[1] = 1'b0;
    step(0);
    chk("conf_gnt2", bus.gnt, 4'b0100);
    act[2] = 1'b0;
    step(0);
    chk("conf_rdata", bus.rdata[2*DW +: DW], 64'h5);

    // Four readers held for four cycles from a fresh reset.
    do_reset();
    for (int i = 0; i < N; i++) begin act[i] = 1'b1; ad[i] = AW'(10'h100 + i); end
    step(0);
    chk("rr_gnt1", bus.gnt, 4'b0011);
    step(0);
    chk("rr_gnt2", bus.gnt, 4'b1100);
    step(0);
    step(0);
    clear_reqs();
    step(0);

    // Two reads to the same address are granted together.
    act[0] = 1'b1; ad[0] = 10'h030;
    act[1] = 1'b1; ad[1] = 10'h030;
    step(0);
    chk("same_gnt", bus.gnt, 4'b0011);
    clear_reqs();
    step(0);
    chk("same_rdata", bus.rdata[DW +: DW], bus.rdata[0 +: DW] === init_word(10'h030) ?
        init_word(10'h030) : ~init_word(10'h030));

    // Write-only access produces no read return.
    act[3] = 1'b1; w[3] = 1'b1; ad[3] = 10'h007; wd[3] = 64'hDEAD;
    step(0);
    chk("wr_wren", wren_a, 1'b1);
    clear_reqs();
    step(0);
    chk("wr_norv", bus.rvalid, 0);
    chk("wr_wren_off", wren_a, 1'b0);

    // Reset pulsed mid-cycle after a read grant: outputs drop at once, read is dropped.
    act[1] = 1'b1; ad[1] = 10'h040;
    step(0);
    reset = 1'b1;
    #1;
    chk("mid_gnt", bus.gnt, 0);
    chk("mid_port", {wren_a, address_a}, 0);
    @(negedge clk);
    bus.req = '0;
    clear_reqs();
    reset  = 1'b0;
    mptr   = 0;
    exp_rv = '0;
    exp_rd = '0;
    step(0);
    for (int i = 0; i < N; i++) begin act[i] = 1'b1; ad[i] = AW'(10'h200 + i); end
    step(0);
    chk("post_rst_gnt", bus.gnt, 4'b0011);
    clear_reqs();
    step(0);

    // Random traffic against the model.
    for (int i = 0; i < N; i++) new_access(i);
    repeat (400) step(1);
    clear_reqs();
    step(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
